// File: rtl/v_pipe_query_rd.sv
// Read-side query pipe for the order-book table: snapshots the current state on accept
// and streams HEAD / LEVEL / LIST results as registered valid/ready beats.
module v_pipe_query_rd #(
    parameter int ENTRIES_N   = 16,
    parameter int KEY_BITS    = 32,
    parameter int VOLUME_BITS = 32,
    parameter int IDX_W       = $clog2(ENTRIES_N) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_cmd_vld,
    input  logic [1:0]                     i_cmd_opcode,
    input  logic [IDX_W-1:0]               i_cmd_idx,
    output logic                           o_cmd_rdy,
    input  logic [ENTRIES_N-1:0]           i_stcur_vld_r,
    input  logic [ENTRIES_N*KEY_BITS-1:0]  i_stcur_keys_r,
    input  logic [ENTRIES_N*VOLUME_BITS-1:0] i_stcur_vols_r,
    output logic                           o_rsp_vld,
    input  logic                           i_rsp_rdy,
    output logic [KEY_BITS-1:0]            o_rsp_key,
    output logic [VOLUME_BITS-1:0]         o_rsp_volume,
    output logic [IDX_W-1:0]               o_rsp_idx,
    output logic                           o_rsp_last,
    output logic                           o_rsp_err,
    output logic                           o_busy
);

    localparam int LVL_W = $clog2(ENTRIES_N);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESP   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [ENTRIES_N-1:0]           snap_vld_q;
    logic [ENTRIES_N*KEY_BITS-1:0]  snap_keys_q;
    logic [ENTRIES_N*VOLUME_BITS-1:0] snap_vols_q;
    logic                           rsp_vld_q, rsp_vld_d;
    logic                           rsp_last_q, rsp_last_d;
    logic                           rsp_err_q;
    logic [KEY_BITS-1:0]            rsp_key_q;
    logic [VOLUME_BITS-1:0]         rsp_vol_q;
    logic [IDX_W-1:0]               rsp_idx_q;

    logic                           cmd_acc_s, rsp_hs_s, lvl_ok_s;
    logic                           first_fnd_s, first_more_s, next_fnd_s, next_more_s;
    logic [IDX_W-1:0]               first_idx_s, next_idx_s;
    logic                           load_s, ent_hit_s, ent_snap_s;
    logic [IDX_W-1:0]               ent_idx_s;
    logic [LVL_W-1:0]               ent_sel_s;
    logic [KEY_BITS-1:0]            ent_key_s;
    logic [VOLUME_BITS-1:0]         ent_vol_s;

    // Lowest set bit of vec, packed as {found, index}.
    function automatic logic [IDX_W:0] first_set(input logic [ENTRIES_N-1:0] vec);
        logic             found;
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int i = ENTRIES_N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [ENTRIES_N-1:0] above_mask(input logic [IDX_W-1:0] cur);
        logic [ENTRIES_N-1:0] m;
        for (int i = 0; i < ENTRIES_N; i++) begin
            m[i] = (IDX_W'(i) > cur);
        end
        return m;
    endfunction

    assign o_cmd_rdy = ~rst & (state_q == ST_IDLE) & ~rsp_vld_q;
    assign cmd_acc_s = i_cmd_vld & o_cmd_rdy;
    assign rsp_hs_s  = rsp_vld_q & i_rsp_rdy;
    assign lvl_ok_s  = (i_cmd_idx < IDX_W'(ENTRIES_N)) && i_stcur_vld_r[i_cmd_idx[LVL_W-1:0]];

    // The first LIST beat is taken from the live bus so it can appear one cycle after accept.
    assign {first_fnd_s, first_idx_s} = first_set(i_stcur_vld_r);
    assign first_more_s = |(i_stcur_vld_r & above_mask(first_idx_s));
    assign {next_fnd_s, next_idx_s}   = first_set(snap_vld_q & above_mask(rsp_idx_q));
    assign next_more_s  = |(snap_vld_q & above_mask(next_idx_s));

    assign ent_sel_s = ent_idx_s[LVL_W-1:0];
    assign ent_key_s = ent_snap_s ? snap_keys_q[ent_sel_s*KEY_BITS +: KEY_BITS]
                                  : i_stcur_keys_r[ent_sel_s*KEY_BITS +: KEY_BITS];
    assign ent_vol_s = ent_snap_s ? snap_vols_q[ent_sel_s*VOLUME_BITS +: VOLUME_BITS]
                                  : i_stcur_vols_r[ent_sel_s*VOLUME_BITS +: VOLUME_BITS];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_acc_s) begin
                    state_d = ((i_cmd_opcode == 2'd2) && first_fnd_s) ? ST_STREAM : ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (rsp_hs_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_STREAM: begin
                if (rsp_hs_s && rsp_last_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Beat selection: decides whether a new beat loads and which entry it carries.
    always_comb begin
        load_s     = 1'b0;
        ent_hit_s  = 1'b0;
        ent_snap_s = 1'b0;
        ent_idx_s  = '0;
        rsp_vld_d  = rsp_vld_q;
        rsp_last_d = rsp_last_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_acc_s) begin
                    load_s     = 1'b1;
                    rsp_vld_d  = 1'b1;
                    rsp_last_d = 1'b1;
                    case (i_cmd_opcode)
                        2'd0: begin
                            ent_hit_s = i_stcur_vld_r[0];
                            ent_idx_s = '0;
                        end
                        2'd1: begin
                            ent_hit_s = lvl_ok_s;
                            ent_idx_s = i_cmd_idx;
                        end
                        2'd2: begin
                            ent_hit_s  = first_fnd_s;
                            ent_idx_s  = first_idx_s;
                            rsp_last_d = ~(first_fnd_s & first_more_s);
                        end
                        default: ent_hit_s = 1'b0;
                    endcase
                end else begin
                    rsp_vld_d = 1'b0;
                end
            end
            ST_RESP: begin
                if (rsp_hs_s) begin
                    rsp_vld_d = 1'b0;
                end else begin
                    rsp_vld_d = rsp_vld_q;
                end
            end
            ST_STREAM: begin
                if (rsp_hs_s && rsp_last_q) begin
                    rsp_vld_d = 1'b0;
                end else if (rsp_hs_s) begin
                    load_s     = 1'b1;
                    rsp_vld_d  = 1'b1;
                    ent_hit_s  = next_fnd_s;
                    ent_snap_s = 1'b1;
                    ent_idx_s  = next_idx_s;
                    rsp_last_d = ~next_more_s;
                end else begin
                    rsp_vld_d = rsp_vld_q;
                end
            end
            default: rsp_vld_d = 1'b0;
        endcase
    end

    // Snapshot capture on accept and registered response beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_vld_q  <= '0;
            snap_keys_q <= '0;
            snap_vols_q <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_key_q   <= '0;
            rsp_vol_q   <= '0;
            rsp_idx_q   <= '0;
        end else begin
            if (cmd_acc_s) begin
                snap_vld_q  <= i_stcur_vld_r;
                snap_keys_q <= i_stcur_keys_r;
                snap_vols_q <= i_stcur_vols_r;
            end
            rsp_vld_q  <= rsp_vld_d;
            rsp_last_q <= rsp_last_d;
            if (load_s) begin
                rsp_err_q <= ~ent_hit_s;
                rsp_key_q <= ent_hit_s ? ent_key_s : '0;
                rsp_vol_q <= ent_hit_s ? ent_vol_s : '0;
                rsp_idx_q <= ent_hit_s ? ent_idx_s : '0;
            end
        end
    end

    assign o_rsp_vld    = rsp_vld_q;
    assign o_rsp_key    = rsp_key_q;
    assign o_rsp_volume = rsp_vol_q;
    assign o_rsp_idx    = rsp_idx_q;
    assign o_rsp_last   = rsp_last_q;
    assign o_rsp_err    = rsp_err_q;
    assign o_busy       = (state_q != ST_IDLE) | rsp_vld_q;

endmodule

// File: tb/tb_v_pipe_query_rd.sv
// Directed bench for v_pipe_query_rd with a 4-entry table; expected beats are hand-computed.
module tb_v_pipe_query_rd;

    localparam int N  = 4;
    localparam int KB = 32;
    localparam int VB = 32;
    localparam int IW = 3;

    logic          clk;
    logic          rst;
    logic          cmd_vld;
    logic [1:0]    cmd_op;
    logic [IW-1:0] cmd_idx;
    logic          cmd_rdy;
    logic [N-1:0]  st_vld;
    logic [N*KB-1:0] st_keys;
    logic [N*VB-1:0] st_vols;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic [KB-1:0] rsp_key;
    logic [VB-1:0] rsp_vol;
    logic [IW-1:0] rsp_idx;
    logic          rsp_last;
    logic          rsp_err;
    logic          busy;

    int errors = 0;
    int checks = 0;

    v_pipe_query_rd #(.ENTRIES_N(N), .KEY_BITS(KB), .VOLUME_BITS(VB), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_vld(cmd_vld), .i_cmd_opcode(cmd_op), .i_cmd_idx(cmd_idx), .o_cmd_rdy(cmd_rdy),
        .i_stcur_vld_r(st_vld), .i_stcur_keys_r(st_keys), .i_stcur_vols_r(st_vols),
        .o_rsp_vld(rsp_vld), .i_rsp_rdy(rsp_rdy), .o_rsp_key(rsp_key), .o_rsp_volume(rsp_vol),
        .o_rsp_idx(rsp_idx), .o_rsp_last(rsp_last), .o_rsp_err(rsp_err), .o_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entry i holds key 100-i and volume 1000+i.
    task automatic set_state(input logic [N-1:0] v);
        st_vld = v;
        for (int i = 0; i < N; i++) begin
            st_keys[i*KB +: KB] = 32'(100 - i);
            st_vols[i*VB +: VB] = 32'(1000 + i);
        end
    endtask

    task automatic issue(input string tag, input logic [1:0] op, input logic [IW-1:0] idx);
        check({tag, "_cmd_rdy"}, 64'(cmd_rdy), 64'd1);
        cmd_vld = 1'b1;
        cmd_op  = op;
        cmd_idx = idx;
        tick();
        cmd_vld = 1'b0;
    endtask

    task automatic exp_entry(input string tag, input int idx, input logic last);
        check({tag, "_vld"},  64'(rsp_vld),  64'd1);
        check({tag, "_key"},  64'(rsp_key),  64'(100 - idx));
        check({tag, "_vol"},  64'(rsp_vol),  64'(1000 + idx));
        check({tag, "_idx"},  64'(rsp_idx),  64'(idx));
        check({tag, "_last"}, 64'(rsp_last), 64'(last));
        check({tag, "_err"},  64'(rsp_err),  64'd0);
    endtask

    task automatic exp_err(input string tag);
        check({tag, "_vld"},  64'(rsp_vld),  64'd1);
        check({tag, "_key"},  64'(rsp_key),  64'd0);
        check({tag, "_vol"},  64'(rsp_vol),  64'd0);
        check({tag, "_idx"},  64'(rsp_idx),  64'd0);
        check({tag, "_last"}, 64'(rsp_last), 64'd1);
        check({tag, "_err"},  64'(rsp_err),  64'd1);
    endtask

    task automatic exp_idle(input string tag);
        check({tag, "_vld"},  64'(rsp_vld), 64'd0);
        check({tag, "_rdy"},  64'(cmd_rdy), 64'd1);
        check({tag, "_busy"}, 64'(busy),    64'd0);
    endtask

    initial begin
        rst = 1'b1; cmd_vld = 1'b0; cmd_op = 2'd0; cmd_idx = '0; rsp_rdy = 1'b1;
        set_state(4'b0000);
        #2;
        check("rst_vld",  64'(rsp_vld),  64'd0);
        check("rst_rdy",  64'(cmd_rdy),  64'd0);
        check("rst_busy", 64'(busy),     64'd0);
        check("rst_last", 64'(rsp_last), 64'd0);
        check("rst_err",  64'(rsp_err),  64'd0);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("rel_rdy", 64'(cmd_rdy), 64'd1);

        // HEAD
        set_state(4'b0011);
        issue("head", 2'd0, 3'd0);
        exp_entry("head", 0, 1'b1);
        check("head_rdy_busy", 64'(cmd_rdy), 64'd0);
        check("head_busy", 64'(busy), 64'd1);
        tick();
        exp_idle("head_done");
        set_state(4'b0000);
        issue("head_empty", 2'd0, 3'd0);
        exp_err("head_empty");
        tick();

        // LEVEL
        set_state(4'b0011);
        issue("lvl2", 2'd1, 3'd2);
        exp_err("lvl2");
        tick();
        issue("lvl1", 2'd1, 3'd1);
        exp_entry("lvl1", 1, 1'b1);
        tick();
        issue("lvl7", 2'd1, 3'd7);
        exp_err("lvl7");
        tick();
        exp_idle("lvl_done");

        // LIST with gap; live state changes after accept must not matter
        set_state(4'b1011);
        issue("list_a", 2'd2, 3'd0);
        exp_entry("list_a0", 0, 1'b0);
        st_vld  = 4'b0000;
        st_keys = {N{32'd555}};
        tick();
        exp_entry("list_a1", 1, 1'b0);
        tick();
        exp_entry("list_a3", 3, 1'b1);
        tick();
        exp_idle("list_a_done");

        // LIST with stalls
        set_state(4'b1111);
        rsp_rdy = 1'b0;
        issue("list_b", 2'd2, 3'd0);
        for (int b = 0; b < N; b++) begin
            exp_entry($sformatf("list_b%0d", b), b, (b == N - 1));
            tick();
            exp_entry($sformatf("list_b%0d_stall", b), b, (b == N - 1));
            check($sformatf("list_b%0d_rdy", b), 64'(cmd_rdy), 64'd0);
            tick();
            rsp_rdy = 1'b1;
            tick();
            rsp_rdy = 1'b0;
        end
        exp_idle("list_b_done");
        rsp_rdy = 1'b1;

        // Empty LIST
        set_state(4'b0000);
        issue("list_empty", 2'd2, 3'd0);
        exp_err("list_empty");
        tick();
        exp_idle("list_empty_done");

        // Reserved opcode
        set_state(4'b1111);
        issue("op3", 2'd3, 3'd0);
        exp_err("op3");
        tick();
        exp_idle("op3_done");

        // Reset mid-LIST
        issue("rstmid", 2'd2, 3'd0);
        exp_entry("rstmid0", 0, 1'b0);
        tick();
        exp_entry("rstmid1", 1, 1'b0);
        rst = 1'b1;
        #1;
        check("rstmid_vld", 64'(rsp_vld), 64'd0);
        check("rstmid_rdy", 64'(cmd_rdy), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rstmid_rel_rdy", 64'(cmd_rdy), 64'd1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("rstmid_quiet%0d", c), 64'(rsp_vld), 64'd0);
        end

        // Command held while busy is taken only once idle
        rsp_rdy = 1'b0;
        issue("busy_list", 2'd2, 3'd0);
        cmd_vld = 1'b1;
        cmd_op  = 2'd0;
        tick();
        exp_entry("busy_hold0", 0, 1'b0);
        rsp_rdy = 1'b1;
        tick();
        exp_entry("busy_b1", 1, 1'b0);
        tick();
        exp_entry("busy_b2", 2, 1'b0);
        tick();
        exp_entry("busy_b3", 3, 1'b1);
        tick();
        check("busy_drop_vld", 64'(rsp_vld), 64'd0);
        check("busy_drop_rdy", 64'(cmd_rdy), 64'd1);
        tick();
        cmd_vld = 1'b0;
        exp_entry("busy_head", 0, 1'b1);
        tick();
        exp_idle("busy_done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
